rv_mem_arbiter: RTL

Arbiter and sequencer that shares one single-port unified memory between the core's instruction-fetch port and data-memory port. Each requester uses a req/gnt/rvalid handshake. The memory has a fixed read latency. The arbiter allows one transaction outstanding at a time, tracks which requester owns it, and routes the response back to that owner. Data accesses have priority over fetches, with a bounded fairness guard so fetches are not starved. The block sits between the core's memory ports and the shared SRAM macro.

---
 rtl/rv_mem_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/rv_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rv_mem_arbiter
// Brief    : Shares one single-port SRAM between instruction fetch (IF) and
//            data memory (DM), with one transaction outstanding at a time.
//            Optional fetch fairness guard: define RV_ARB_FAIRNESS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module rv_mem_arbiter #(
    parameter int XLEN         = 32,
    parameter int MEM_LAT      = 1,
    parameter int DM_MAX_BURST = 4
) (
    input  logic              i_arb_clk,
    input  logic              i_arb_rst,
    input  logic              i_arb_if_req,
    input  logic [XLEN-1:0]   i_arb_if_addr,
    output logic              o_arb_if_gnt,
    output logic              o_arb_if_rvalid,
    output logic [XLEN-1:0]   o_arb_if_rdata,
    input  logic              i_arb_dm_req,
    input  logic [XLEN-1:0]   i_arb_dm_addr,
    input  logic              i_arb_dm_wen,
    input  logic [XLEN/8-1:0] i_arb_dm_wstrb,
    input  logic [XLEN-1:0]   i_arb_dm_wdata,
    output logic              o_arb_dm_gnt,
    output logic              o_arb_dm_rvalid,
    output logic [XLEN-1:0]   o_arb_dm_rdata,
    output logic              o_arb_mem_en,
    output logic              o_arb_mem_wen,
    output logic [XLEN-1:0]   o_arb_mem_addr,
    output logic [XLEN/8-1:0] o_arb_mem_wstrb,
    output logic [XLEN-1:0]   o_arb_mem_wdata,
    input  logic [XLEN-1:0]   i_arb_mem_rdata
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam logic [2:0] c_lat_init = 3'(MEM_LAT);

    state_t     r_state;
    logic [2:0] r_lat_cnt;
    logic       r_owner_dm;
    logic       r_is_write;

    logic w_done;
    logic w_idle;
    logic w_force_if;
    logic w_gnt_if;
    logic w_gnt_dm;
    logic w_rvalid;

    // The response cycle doubles as an idle cycle so a new grant can
    // overlap the rvalid of the previous transaction.
    assign w_done   = (r_state == ST_BUSY) && (r_lat_cnt == 3'd1);
    assign w_idle   = !i_arb_rst && ((r_state == ST_IDLE) || w_done);
    assign w_rvalid = !i_arb_rst && w_done;

    assign w_gnt_dm = w_idle && i_arb_dm_req && !(i_arb_if_req && w_force_if);
    assign w_gnt_if = w_idle && i_arb_if_req && !w_gnt_dm;

`ifdef RV_ARB_FAIRNESS_EN
    logic [3:0] r_dm_streak;

    always_ff @(posedge i_arb_clk) begin
        if (i_arb_rst) begin
            r_dm_streak <= 4'd0;
        end else if (w_gnt_if || !i_arb_if_req) begin
            r_dm_streak <= 4'd0;
        end else if (w_gnt_dm) begin
            r_dm_streak <= r_dm_streak + 4'd1;
        end
    end

    assign w_force_if = (r_dm_streak == 4'(DM_MAX_BURST));
`else
    // Strict DM priority: the burst limit is legal-range only, so this is 0.
    assign w_force_if = (DM_MAX_BURST < 0);
`endif

    always_ff @(posedge i_arb_clk) begin
        if (i_arb_rst) begin
            r_state    <= ST_IDLE;
            r_lat_cnt  <= 3'd0;
            r_owner_dm <= 1'b0;
            r_is_write <= 1'b0;
        end else if (w_gnt_if || w_gnt_dm) begin
            r_state    <= ST_BUSY;
            r_lat_cnt  <= c_lat_init;
            r_owner_dm <= w_gnt_dm;
            r_is_write <= w_gnt_dm && i_arb_dm_wen;
        end else if (r_state == ST_BUSY) begin
            if (w_done) begin
                r_state   <= ST_IDLE;
                r_lat_cnt <= 3'd0;
            end else begin
                r_lat_cnt <= r_lat_cnt - 3'd1;
            end
        end
    end

    assign o_arb_if_gnt    = w_gnt_if;
    assign o_arb_dm_gnt    = w_gnt_dm;

    assign o_arb_mem_en    = w_gnt_if || w_gnt_dm;
    assign o_arb_mem_wen   = w_gnt_dm && i_arb_dm_wen;
    assign o_arb_mem_addr  = w_gnt_dm ? i_arb_dm_addr :
                             (w_gnt_if ? i_arb_if_addr : '0);
    assign o_arb_mem_wstrb = w_gnt_dm ? i_arb_dm_wstrb : '0;
    assign o_arb_mem_wdata = w_gnt_dm ? i_arb_dm_wdata : '0;

    assign o_arb_if_rvalid = w_rvalid && !r_owner_dm;
    assign o_arb_dm_rvalid = w_rvalid && r_owner_dm;
    assign o_arb_if_rdata  = o_arb_if_rvalid ? i_arb_mem_rdata : '0;
    assign o_arb_dm_rdata  = (o_arb_dm_rvalid && !r_is_write) ? i_arb_mem_rdata : '0;

endmodule
`default_nettype wire
